// File: rtl/vu_cmd_sequencer.sv
// Vector-unit command sequencer: owns cmdq/ximm1q and pairs commands with immediates for issue.
// Optional stall statistics enabled by defining VU_CMD_SEQ_STALL_STATS_EN.
module vu_cmd_sequencer #(
  parameter int CMD_W     = 8,
  parameter int IMM_W     = 64,
  parameter int CMD_DEPTH = 4,
  parameter int IMM_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_enq_cmdq_valid,
  input  logic [CMD_W-1:0] io_enq_cmdq_bits,
  output logic             io_cmdq_ready,
  input  logic             io_enq_ximm1q_valid,
  input  logic [IMM_W-1:0] io_enq_ximm1q_bits,
  output logic             io_ximm1q_ready,
  output logic             io_issue_valid,
  output logic [CMD_W-1:0] io_issue_cmd,
  output logic [IMM_W-1:0] io_issue_imm,
  input  logic             io_issue_ready,
`ifdef VU_CMD_SEQ_STALL_STATS_EN
  output logic [15:0]      io_stall_count,
`endif
  output logic             io_busy
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int IPW = $clog2(IMM_DEPTH);
  localparam logic [CPW:0] C_FULL = (CPW+1)'(CMD_DEPTH);
  localparam logic [IPW:0] I_FULL = (IPW+1)'(IMM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_IMM = 2'd1,
    S_ISSUE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [IMM_W-1:0] imm_q, imm_d;

  logic [CMD_W-1:0] c_mem_q [CMD_DEPTH];
  logic [CPW-1:0]   c_rd_q, c_wr_q;
  logic [CPW:0]     c_cnt_q;
  logic [IMM_W-1:0] i_mem_q [IMM_DEPTH];
  logic [IPW-1:0]   i_rd_q, i_wr_q;
  logic [IPW:0]     i_cnt_q;

  logic c_push_s, c_pop_s, c_empty_s;
  logic i_push_s, i_pop_s, i_empty_s;

  // Ready depends only on registered occupancy, so a full queue refuses even while popping.
  assign io_cmdq_ready   = (c_cnt_q < C_FULL);
  assign io_ximm1q_ready = (i_cnt_q < I_FULL);
  assign c_push_s        = io_enq_cmdq_valid & io_cmdq_ready;
  assign i_push_s        = io_enq_ximm1q_valid & io_ximm1q_ready;
  assign c_empty_s       = (c_cnt_q == '0);
  assign i_empty_s       = (i_cnt_q == '0);

  assign io_issue_valid = (state_q == S_ISSUE);
  assign io_issue_cmd   = cmd_q;
  assign io_issue_imm   = imm_q;
  assign io_busy        = !c_empty_s | !i_empty_s | (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    imm_d   = imm_q;
    c_pop_s = 1'b0;
    i_pop_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!c_empty_s) begin
          c_pop_s = 1'b1;
          cmd_d   = c_mem_q[c_rd_q];
          imm_d   = '0;
          if (c_mem_q[c_rd_q][CMD_W-1]) begin
            state_d = S_WAIT_IMM;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_IMM: begin
        if (!i_empty_s) begin
          i_pop_s = 1'b1;
          imm_d   = i_mem_q[i_rd_q];
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT_IMM;
        end
      end
      S_ISSUE: begin
        if (io_issue_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      imm_q   <= imm_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CMD_DEPTH; k++) c_mem_q[k] <= '0;
      c_rd_q  <= '0;
      c_wr_q  <= '0;
      c_cnt_q <= '0;
    end else begin
      if (c_push_s) begin
        c_mem_q[c_wr_q] <= io_enq_cmdq_bits;
        c_wr_q          <= c_wr_q + 1'b1;
      end
      if (c_pop_s) begin
        c_rd_q <= c_rd_q + 1'b1;
      end
      case ({c_push_s, c_pop_s})
        2'b10:   c_cnt_q <= c_cnt_q + 1'b1;
        2'b01:   c_cnt_q <= c_cnt_q - 1'b1;
        default: c_cnt_q <= c_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < IMM_DEPTH; k++) i_mem_q[k] <= '0;
      i_rd_q  <= '0;
      i_wr_q  <= '0;
      i_cnt_q <= '0;
    end else begin
      if (i_push_s) begin
        i_mem_q[i_wr_q] <= io_enq_ximm1q_bits;
        i_wr_q          <= i_wr_q + 1'b1;
      end
      if (i_pop_s) begin
        i_rd_q <= i_rd_q + 1'b1;
      end
      case ({i_push_s, i_pop_s})
        2'b10:   i_cnt_q <= i_cnt_q + 1'b1;
        2'b01:   i_cnt_q <= i_cnt_q - 1'b1;
        default: i_cnt_q <= i_cnt_q;
      endcase
    end
  end

`ifdef VU_CMD_SEQ_STALL_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles a command waits on an empty ximm1q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 16'd0;
    end else if ((state_q == S_WAIT_IMM) && i_empty_s && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign io_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_vu_cmd_sequencer.sv
// Self-checking bench for vu_cmd_sequencer: queue-based reference model plus directed scenarios.
module tb_vu_cmd_sequencer;
  localparam int CMD_W = 8;
  localparam int IMM_W = 64;
  localparam int CD    = 4;
  localparam int ID    = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enq_c_v;
  logic [CMD_W-1:0] enq_c_b;
  logic             io_cmdq_ready;
  logic             enq_i_v;
  logic [IMM_W-1:0] enq_i_b;
  logic             io_ximm1q_ready;
  logic             io_issue_valid;
  logic [CMD_W-1:0] io_issue_cmd;
  logic [IMM_W-1:0] io_issue_imm;
  logic             issue_ready;
  logic             io_busy;
`ifdef VU_CMD_SEQ_STALL_STATS_EN
  logic [15:0]      io_stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vu_cmd_sequencer #(.CMD_W(CMD_W), .IMM_W(IMM_W), .CMD_DEPTH(CD), .IMM_DEPTH(ID)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .io_enq_cmdq_valid   (enq_c_v),
    .io_enq_cmdq_bits    (enq_c_b),
    .io_cmdq_ready       (io_cmdq_ready),
    .io_enq_ximm1q_valid (enq_i_v),
    .io_enq_ximm1q_bits  (enq_i_b),
    .io_ximm1q_ready     (io_ximm1q_ready),
    .io_issue_valid      (io_issue_valid),
    .io_issue_cmd        (io_issue_cmd),
    .io_issue_imm        (io_issue_imm),
    .io_issue_ready      (issue_ready),
`ifdef VU_CMD_SEQ_STALL_STATS_EN
    .io_stall_count      (io_stall_count),
`endif
    .io_busy             (io_busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: two FIFOs and one "held command" slot that may still be missing its immediate.
  logic [CMD_W-1:0] mq_c[$];
  logic [IMM_W-1:0] mq_i[$];
  logic [CMD_W-1:0] m_issued[$];
  bit               m_hold;
  bit               m_need;
  logic [CMD_W-1:0] m_cmd;
  logic [IMM_W-1:0] m_imm;
  int               m_stall;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq_c.delete();
      mq_i.delete();
      m_hold  = 1'b0;
      m_need  = 1'b0;
      m_cmd   = '0;
      m_imm   = '0;
      m_stall = 0;
    end else begin
      int  sc;
      int  si;
      bit  pc;
      bit  pi;
      sc = mq_c.size();
      si = mq_i.size();
      pc = enq_c_v && (sc < CD);
      pi = enq_i_v && (si < ID);
      if (!m_hold) begin
        if (sc > 0) begin
          m_cmd  = mq_c.pop_front();
          m_imm  = '0;
          m_hold = 1'b1;
          m_need = m_cmd[CMD_W-1];
        end
      end else if (m_need) begin
        if (si > 0) begin
          m_imm  = mq_i.pop_front();
          m_need = 1'b0;
        end else if (m_stall < 65535) begin
          m_stall = m_stall + 1;
        end
      end else if (issue_ready) begin
        m_issued.push_back(m_cmd);
        m_hold = 1'b0;
      end
      if (pc) mq_c.push_back(enq_c_b);
      if (pi) mq_i.push_back(enq_i_b);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("m_cmdq_ready", 64'(io_cmdq_ready), 64'(mq_c.size() < CD));
    chk("m_ximm_ready", 64'(io_ximm1q_ready), 64'(mq_i.size() < ID));
    chk("m_valid", 64'(io_issue_valid), 64'(m_hold && !m_need));
    chk("m_busy", 64'(io_busy), 64'((mq_c.size() != 0) || (mq_i.size() != 0) || m_hold));
    if (m_hold && !m_need) begin
      chk("m_cmd", 64'(io_issue_cmd), 64'(m_cmd));
      chk("m_imm", io_issue_imm, m_imm);
    end
`ifdef VU_CMD_SEQ_STALL_STATS_EN
    chk("m_stall", 64'(io_stall_count), 64'(m_stall));
`endif
  end

  task automatic push_cmd(input logic [CMD_W-1:0] c);
    enq_c_v = 1'b1;
    enq_c_b = c;
    @(negedge clk);
    enq_c_v = 1'b0;
  endtask

  task automatic push_imm(input logic [IMM_W-1:0] v);
    enq_i_v = 1'b1;
    enq_i_b = v;
    @(negedge clk);
    enq_i_v = 1'b0;
  endtask

  task automatic accept();
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
  endtask

  initial begin
    logic [CMD_W-1:0] exp_iss [5];
    enq_c_v = 1'b0; enq_c_b = '0;
    enq_i_v = 1'b0; enq_i_b = '0;
    issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(io_issue_valid), 64'h0);
    chk("rst_cmd", 64'(io_issue_cmd), 64'h0);
    chk("rst_imm", io_issue_imm, 64'h0);
    chk("rst_cmdq_ready", 64'(io_cmdq_ready), 64'h1);
    chk("rst_ximm_ready", 64'(io_ximm1q_ready), 64'h1);
    chk("rst_busy", 64'(io_busy), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Plain command: valid two cycles after enqueue.
    push_cmd(8'h05);
    chk("t1_early_valid", 64'(io_issue_valid), 64'h0);
    @(negedge clk);
    chk("t1_valid", 64'(io_issue_valid), 64'h1);
    chk("t1_cmd", 64'(io_issue_cmd), 64'h05);
    chk("t1_imm", io_issue_imm, 64'h0);
    accept();
    chk("t1_busy_after", 64'(io_busy), 64'h0);
    chk("t1_valid_after", 64'(io_issue_valid), 64'h0);

    // Immediate already queued: valid three cycles after the command enqueue.
    push_imm(64'hDEAD);
    push_cmd(8'h81);
    chk("t2_v1", 64'(io_issue_valid), 64'h0);
    @(negedge clk);
    chk("t2_v2", 64'(io_issue_valid), 64'h0);
    @(negedge clk);
    chk("t2_valid", 64'(io_issue_valid), 64'h1);
    chk("t2_cmd", 64'(io_issue_cmd), 64'h81);
    chk("t2_imm", io_issue_imm, 64'hDEAD);
    accept();

    // Waiting on a late immediate.
    push_cmd(8'h81);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_wait_valid", 64'(io_issue_valid), 64'h0);
    end
    push_imm(64'h1234);
    chk("t3_v1", 64'(io_issue_valid), 64'h0);
    @(negedge clk);
    chk("t3_valid", 64'(io_issue_valid), 64'h1);
    chk("t3_imm", io_issue_imm, 64'h1234);
    accept();

    // Fill cmdq while the sequencer stalls; the last push must be refused.
    for (int k = 0; k < 6; k++) begin
      enq_c_v = 1'b1;
      enq_c_b = 8'h11 + 8'(k);
      @(negedge clk);
    end
    enq_c_v = 1'b0;
    chk("t4_cmdq_full", 64'(io_cmdq_ready), 64'h0);
    chk("t4_cmd_held", 64'(io_issue_cmd), 64'h11);

    // Push in the same cycle cmdq pops from full: refused, ready returns next cycle.
    accept();
    chk("t5_still_full", 64'(io_cmdq_ready), 64'h0);
    push_cmd(8'h17);
    chk("t5_ready_back", 64'(io_cmdq_ready), 64'h1);
    chk("t5_cmd", 64'(io_issue_cmd), 64'h12);
    accept();
    @(negedge clk);
    chk("t6_in_issue", 64'(io_issue_valid), 64'h1);
    chk("t6_cmd", 64'(io_issue_cmd), 64'h13);

    // Asynchronous reset in ISSUE with two entries queued.
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(io_issue_valid), 64'h0);
    chk("t6_rst_cmdq_ready", 64'(io_cmdq_ready), 64'h1);
    chk("t6_rst_ximm_ready", 64'(io_ximm1q_ready), 64'h1);
    chk("t6_rst_busy", 64'(io_busy), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_stale", 64'(io_issue_valid), 64'h0);
    end
    exp_iss[0] = 8'h05; exp_iss[1] = 8'h81; exp_iss[2] = 8'h81;
    exp_iss[3] = 8'h11; exp_iss[4] = 8'h12;
    chk("model_issue_count", 64'(m_issued.size()), 64'd5);
    for (int k = 0; k < 5 && k < m_issued.size(); k++) begin
      chk("model_issue_order", 64'(m_issued[k]), 64'(exp_iss[k]));
    end

    // Surplus immediate stays queued until a needs_imm command takes it.
    push_imm(64'hAA);
    push_cmd(8'h05);
    @(negedge clk);
    chk("t7_valid", 64'(io_issue_valid), 64'h1);
    chk("t7_imm_zero", io_issue_imm, 64'h0);
    accept();
    chk("t7_busy_imm_left", 64'(io_busy), 64'h1);
    push_cmd(8'h82);
    repeat (2) @(negedge clk);
    chk("t7b_valid", 64'(io_issue_valid), 64'h1);
    chk("t7b_imm", io_issue_imm, 64'hAA);
    accept();
    chk("t7b_busy", 64'(io_busy), 64'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
